seq_event_reporter: RTL
=======================

SEQ_EVENT_REPORTER -- requirements
Module: seq_event_reporter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of total_cnt, drop_cnt and evt_seq.
REQ-002 SHALL have parameter TS_W, default 16, width of timestamp counter and evt_stamp.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port det_in  input  1  detect output of upstream Moore sequence detector.
REQ-006 SHALL have port clear  input  1  synchronous clear of all counters, FIFO and flags.
REQ-007 SHALL have port evt_valid  output  1  FIFO head holds an event.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts head when evt_valid=1.
REQ-009 SHALL have port evt_seq  output  CNT_W  sequence number of head event.
REQ-010 SHALL have port evt_stamp  output  TS_W  timestamp of head event.
REQ-011 SHALL have port total_cnt  output  CNT_W  saturating count of all detected events.
REQ-012 SHALL have port drop_cnt  output  CNT_W  saturating count of events lost to full FIFO.
REQ-013 SHALL have port overflow  output  1  sticky: at least one event dropped since reset/clear.

Function
REQ-014 SHALL register det_in into det_q; event = det_in & ~det_q (rising edge only); det_in held high N cycles = one event.
REQ-015 SHALL run free-running TS_W timestamp counter, +1 every cycle, wraps max->0.
REQ-016 SHALL on event: total_cnt +1, saturating at all-ones (no wrap); evt_seq of new entry = total_cnt value before increment (wraps modulo 2^CNT_W, independent of saturation).
REQ-017 SHALL buffer events in 2-entry FIFO, states EMPTY, ONE, FULL; entry = {seq, stamp}; stamp = timestamp value before the capturing edge.
REQ-018 SHALL use transitions: EMPTY+event->ONE; ONE+event(no pop)->FULL; ONE+pop(no event)->EMPTY; FULL+pop(no event)->ONE; push+pop same cycle -> state unchanged.
REQ-019 SHALL define pop = evt_valid & evt_ready; evt_valid=1 in ONE and FULL; head data stable while evt_valid=1 and evt_ready=0.
REQ-020 SHALL in FULL with event and simultaneous pop accept the event (no drop); in FULL with event and no pop drop it: drop_cnt +1 saturating, overflow<=1, FIFO unchanged.
REQ-021 SHALL have latency: event at edge k -> evt_valid=1 after edge k when FIFO was EMPTY (one cycle from det_in rise being sampled).
REQ-022 SHALL give clear priority over event and pop in the same cycle: the event is not counted, not stored, and not dropped.
REQ-023 SHALL ignore evt_ready when evt_valid=0.

Reset
REQ-024 SHALL on reset=0 asynchronously force: det_q=0, timestamp=0, FIFO EMPTY, evt_valid=0, evt_seq=0, evt_stamp=0, total_cnt=0, drop_cnt=0, overflow=0.
REQ-025 SHALL on clear=1 at an edge load the same values as REQ-024 synchronously; an event pending at mid-operation reset/clear SHALL be discarded.
REQ-026 SHALL resume normal operation on the first rising edge after reset deasserts; det_in high at that edge counts as an event.

Configuration
REQ-027 SHALL use macro SEQ_EVT_STAMP_EN: defined -> timestamp counter built and evt_stamp carries captured timestamps.
REQ-028 SHALL when SEQ_EVT_STAMP_EN is undefined: no timestamp counter, no stamp storage in FIFO, evt_stamp tied to 0; all other behaviour identical.

Verification
REQ-029 SHALL verify: reset, evt_ready=1, det_in pulse high 1 cycle at edge 5 after release -> evt_valid=1 one cycle, evt_seq=0, evt_stamp=4, total_cnt=1.
REQ-030 SHALL verify: det_in held high 4 cycles -> exactly one event, total_cnt=1.
REQ-031 SHALL verify: evt_ready=0, three 1-cycle det_in pulses spaced 3 cycles -> FIFO FULL with seq 0,1; drop_cnt=1, overflow=1, total_cnt=3; then evt_ready=1 -> seq 0 then 1 popped, evt_valid=0.
REQ-032 SHALL verify: FIFO FULL, event coincident with pop -> no drop, state stays FULL, new tail seq=2.
REQ-033 SHALL verify: 260 events with evt_ready=1 -> total_cnt=255 saturated, evt_seq of last event=3 (wrapped); then clear=1 coincident with an event -> all outputs 0, event not counted.
REQ-034 SHALL verify: reset asserted mid-cycle while FULL -> evt_valid, counters, overflow 0 immediately without clock edge.

Source files
------------

// File: rtl/seq_event_reporter.sv
// Edge-detects det_in, numbers/timestamps each event and queues it in a 2-entry FIFO
// with saturating total/drop counters. Optional macro: SEQ_EVT_STAMP_EN (timestamp path).
module seq_event_reporter #(
  parameter int CNT_W = 8,
  parameter int TS_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det_in,
  input  logic             clear,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_seq,
  output logic [TS_W-1:0]  evt_stamp,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           r_state, w_state_nx;
  logic             r_det_q;
  logic [CNT_W-1:0] r_seq0, r_seq1, r_seq_cnt, r_total, r_drop;
  logic             r_ovf;
  logic             w_evt, w_push, w_pop, w_drop;
  logic             w_ld0_new, w_ld0_shift, w_ld1_new;

  assign evt_valid = (r_state != EMPTY);
  assign evt_seq   = r_seq0;
  assign total_cnt = r_total;
  assign drop_cnt  = r_drop;
  assign overflow  = r_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_state <= EMPTY;
    else if (clear) r_state <= EMPTY;
    else            r_state <= w_state_nx;
  end

  // Slot 0 is the head; slot 1 only ever holds the tail while FULL.
  always_comb begin
    w_evt       = det_in & ~r_det_q;
    w_push      = w_evt & ~clear;
    w_pop       = evt_valid & evt_ready;
    w_state_nx  = r_state;
    w_ld0_new   = 1'b0;
    w_ld0_shift = 1'b0;
    w_ld1_new   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_state_nx = ONE;
          w_ld0_new  = 1'b1;
        end
      end
      ONE: begin
        if (w_push && w_pop) begin
          w_ld0_new = 1'b1;
        end else if (w_push) begin
          w_state_nx = FULL;
          w_ld1_new  = 1'b1;
        end else if (w_pop) begin
          w_state_nx = EMPTY;
        end
      end
      FULL: begin
        if (w_push && w_pop) begin
          w_ld0_shift = 1'b1;
          w_ld1_new   = 1'b1;
        end else if (w_pop) begin
          w_state_nx  = ONE;
          w_ld0_shift = 1'b1;
        end else if (w_push) begin
          w_drop = 1'b1;
        end
      end
      default: w_state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_det_q   <= 1'b0;
      r_seq0    <= '0;
      r_seq1    <= '0;
      r_seq_cnt <= '0;
      r_total   <= '0;
      r_drop    <= '0;
      r_ovf     <= 1'b0;
    end else if (clear) begin
      r_det_q   <= 1'b0;
      r_seq0    <= '0;
      r_seq1    <= '0;
      r_seq_cnt <= '0;
      r_total   <= '0;
      r_drop    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_det_q <= det_in;
      if (w_ld0_new)        r_seq0 <= r_seq_cnt;
      else if (w_ld0_shift) r_seq0 <= r_seq1;
      if (w_ld1_new)        r_seq1 <= r_seq_cnt;
      // Sequence number wraps freely even after total_cnt saturates.
      if (w_push) begin
        r_seq_cnt <= r_seq_cnt + 1'b1;
        if (r_total != '1) r_total <= r_total + 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != '1) r_drop <= r_drop + 1'b1;
      end
    end
  end

`ifdef SEQ_EVT_STAMP_EN
  logic [TS_W-1:0] r_ts, r_stamp0, r_stamp1;

  assign evt_stamp = r_stamp0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts     <= '0;
      r_stamp0 <= '0;
      r_stamp1 <= '0;
    end else if (clear) begin
      r_ts     <= '0;
      r_stamp0 <= '0;
      r_stamp1 <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (w_ld0_new)        r_stamp0 <= r_ts;
      else if (w_ld0_shift) r_stamp0 <= r_stamp1;
      if (w_ld1_new)        r_stamp1 <= r_ts;
    end
  end
`else
  assign evt_stamp = '0;
`endif

endmodule
